cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32 core. It steps each instruction through fetch, decode, execute/memory and writeback over a single shared memory port with a req/ack handshake. It holds the instruction register that feeds the combinational decoder, and it drives the register-file and PC write strobes. It stops the core on `ebreak`, on an unsupported opcode, or on a memory timeout.

---
 rtl/cpu_sequencer.sv | 97 +++++++++
 tb/tb_cpu_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/writeback control for the RV32 core
module cpu_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic [31:0]      ir,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halt,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         wait_q, wait_d;
    logic [31:0]        ir_q, ir_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic               in_mem, timeout, is_alu, is_store, is_ebreak;

    assign in_mem    = state_q == S_FETCH || state_q == S_MEM;
    assign timeout   = !mem_ack && wait_q == 8'(TIMEOUT - 1);
    assign is_alu    = ir_q[6:0] == 7'b0010011 || ir_q[6:0] == 7'b0110011;
    assign is_store  = ir_q[6:0] == 7'b0100011;
    assign is_ebreak = ir_q[6:0] == 7'b1110011;

    // State and datapath registers; reset drops every strobe immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next state: ack wins over timeout on the last allowed wait cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = start ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = mem_ack ? S_DECODE : (timeout ? S_HALT : S_FETCH);
            S_DECODE: state_d = is_alu ? S_EXEC : (is_store ? S_MEM : S_HALT);
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_MEM:    state_d = mem_ack ? S_FETCH : (timeout ? S_HALT : S_MEM);
            default:  state_d = S_HALT;
        endcase
    end

    // Datapath next values; wait count restarts whenever a memory state is (re)entered
    always_comb begin
        wait_d    = (in_mem && state_d == state_q) ? wait_q + 8'd1 : 8'd0;
        ir_d      = (state_q == S_FETCH && mem_ack) ? mem_rdata : ir_q;
        retired_d = pc_we ? retired_q + CNT_W'(1) : retired_q;
        illegal_d = illegal_q | (state_q == S_DECODE && !is_alu && !is_store && !is_ebreak);
        bus_err_d = bus_err_q | (in_mem && timeout);
    end

    // Outputs decoded from state; pc_we in MEM is qualified by the ack
    always_comb begin
        mem_req      = in_mem;
        mem_we       = state_q == S_MEM;
        mem_addr_sel = state_q == S_MEM;
        rf_we        = state_q == S_WB;
        pc_we        = state_q == S_WB || (state_q == S_MEM && mem_ack);
        halt         = state_q == S_HALT;
        illegal      = illegal_q;
        bus_err      = bus_err_q;
        ir           = ir_q;
        retired      = retired_q;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: instruction-level trace model checked against the sequencer every cycle
module tb_cpu_sequencer;

    localparam int TO = 4;
    localparam int CW = 4;
    localparam logic [31:0] ADDI   = 32'h00500093;
    localparam logic [31:0] STORE  = 32'h00112023;
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] LUI    = 32'h00000037;
    localparam logic [31:0] JUNK   = 32'hDEADBEEF;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, mem_ack = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          mem_req, mem_we, mem_addr_sel, rf_we, pc_we, halt, illegal, bus_err;
    logic [31:0]   ir;
    logic [CW-1:0] retired;

    cpu_sequencer #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir(ir),
        .rf_we(rf_we), .pc_we(pc_we), .halt(halt), .illegal(illegal), .bus_err(bus_err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // flags = {mem_req, mem_we, mem_addr_sel, rf_we, pc_we, halt, illegal, bus_err}
    typedef struct {
        logic          start;
        logic          ack;
        logic [31:0]   rdata;
        logic [7:0]    flags;
        logic [CW-1:0] ret;
        logic [31:0]   ir;
    } cyc_t;

    cyc_t          q[$];
    int            checks = 0, errors = 0, cyc = 0;
    logic [CW-1:0] m_ret;
    logic [31:0]   m_ir;
    logic          m_halted, m_ill, m_berr;

    // strobes = {mem_req, mem_we, mem_addr_sel, rf_we, pc_we}
    task automatic push(input logic st, input logic ak, input logic [31:0] rd, input logic [4:0] strobes);
        cyc_t c;
        c = '{st, ak, rd, {strobes, m_halted, m_ill, m_berr}, m_ret, m_ir};
        q.push_back(c);
    endtask

    task automatic go();
        push(1'b0, 1'b1, JUNK, 5'b00000);
        push(1'b1, 1'b0, JUNK, 5'b00000);
    endtask

    // One instruction: fw/mw are the wait cycles before the fetch/store ack (>= TO means no ack)
    task automatic instr(input logic [31:0] w, input int fw, input int mw);
        for (int i = 0; i < fw && i < TO; i++) push(1'b0, 1'b0, JUNK, 5'b10000);
        if (fw >= TO) begin
            m_halted = 1'b1;
            m_berr   = 1'b1;
            return;
        end
        push(1'b0, 1'b1, w, 5'b10000);
        m_ir = w;
        push(1'b0, 1'b1, JUNK, 5'b00000);
        case (w[6:0])
            7'b0010011, 7'b0110011: begin
                push(1'b0, 1'b1, JUNK, 5'b00000);
                push(1'b0, 1'b1, JUNK, 5'b00011);
                m_ret = m_ret + 1'b1;
            end
            7'b0100011: begin
                for (int i = 0; i < mw && i < TO; i++) push(1'b0, 1'b0, JUNK, 5'b11100);
                if (mw >= TO) begin
                    m_halted = 1'b1;
                    m_berr   = 1'b1;
                    return;
                end
                push(1'b0, 1'b1, JUNK, 5'b11101);
                m_ret = m_ret + 1'b1;
            end
            7'b1110011: m_halted = 1'b1;
            default: begin
                m_halted = 1'b1;
                m_ill    = 1'b1;
            end
        endcase
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) push(i[0], 1'b1, JUNK, 5'b00000);
    endtask

    task automatic run();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            start     = c.start;
            mem_ack   = c.ack;
            mem_rdata = c.rdata;
            @(negedge clk);
            checks++;
            if ({mem_req, mem_we, mem_addr_sel, rf_we, pc_we, halt, illegal, bus_err} !== c.flags ||
                retired !== c.ret || ir !== c.ir) begin
                errors++;
                $display("FAIL trace cycle %0d: flags=%b retired=%0d ir=%h, expected flags=%b retired=%0d ir=%h",
                         cyc, {mem_req, mem_we, mem_addr_sel, rf_we, pc_we, halt, illegal, bus_err},
                         retired, ir, c.flags, c.ret, c.ir);
            end
            cyc++;
        end
    endtask

    task automatic lit(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ret = '0; m_ir = '0; m_halted = 1'b0; m_ill = 1'b0; m_berr = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        lit("reset_flags", {24'd0, mem_req, mem_we, mem_addr_sel, rf_we, pc_we, halt, illegal, bus_err}, 32'd0);
        lit("reset_retired", 32'(retired), 32'd0);
        lit("reset_ir", ir, 32'd0);
        release_reset();
    endtask

    initial begin
        model_reset();
        // ADDI zero-wait, store with 3 waits, ADDI acked on last fetch cycle, then fetch timeout
        do_reset();
        go();
        instr(ADDI, 0, 0);
        run();
        lit("addi_wb_rf_we", 32'(rf_we), 32'd1);
        lit("addi_wb_pc_we", 32'(pc_we), 32'd1);
        instr(STORE, 0, 3);
        run();
        lit("store_ack_pc_we", 32'(pc_we), 32'd1);
        lit("store_ack_mem_we", 32'(mem_we), 32'd1);
        lit("store_ack_retired", 32'(retired), 32'd1);
        instr(ADDI, 3, 0);
        instr(32'h12345678, 4, 0);
        halt_cycles(3);
        run();
        lit("timeout_bus_err", 32'(bus_err), 32'd1);
        lit("timeout_halt", 32'(halt), 32'd1);
        lit("timeout_ir_held", ir, ADDI);
        lit("timeout_retired", 32'(retired), 32'd3);
        // ebreak: halts without retiring, start ignored afterwards
        do_reset();
        go();
        instr(EBREAK, 1, 0);
        halt_cycles(4);
        run();
        lit("ebreak_halt", 32'(halt), 32'd1);
        lit("ebreak_causes", {30'd0, illegal, bus_err}, 32'd0);
        lit("ebreak_retired", 32'(retired), 32'd0);
        // unsupported opcode
        do_reset();
        go();
        instr(LUI, 0, 0);
        halt_cycles(2);
        run();
        lit("lui_illegal", 32'(illegal), 32'd1);
        lit("lui_bus_err", 32'(bus_err), 32'd0);
        // reset dropped while a store waits for its ack
        do_reset();
        go();
        instr(ADDI, 0, 0);
        instr(ADDI, 1, 0);
        push(1'b0, 1'b0, JUNK, 5'b10000);
        push(1'b0, 1'b1, STORE, 5'b10000);
        m_ir = STORE;
        push(1'b0, 1'b0, JUNK, 5'b00000);
        push(1'b0, 1'b0, JUNK, 5'b11100);
        push(1'b0, 1'b0, JUNK, 5'b11100);
        run();
        lit("pre_reset_req", 32'(mem_req), 32'd1);
        lit("pre_reset_retired", 32'(retired), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        lit("async_reset_req", 32'(mem_req), 32'd0);
        lit("async_reset_we", 32'(mem_we), 32'd0);
        lit("async_reset_retired", 32'(retired), 32'd0);
        lit("async_reset_ir", ir, 32'd0);
        model_reset();
        release_reset();
        // sixteen ADDIs wrap the 4-bit counter, then a store that times out
        go();
        for (int i = 0; i < 16; i++) instr(ADDI, i % 3, 0);
        run();
        lit("wrap_last_pc_we", 32'(pc_we), 32'd1);
        lit("wrap_pre_retired", 32'(retired), 32'd15);
        instr(STORE, 0, 4);
        halt_cycles(3);
        run();
        lit("wrap_retired", 32'(retired), 32'd0);
        lit("store_timeout_bus_err", 32'(bus_err), 32'd1);
        lit("store_timeout_illegal", 32'(illegal), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
